// File: rtl/aes_job_scheduler.sv
// Round-robin job scheduler sharing one pipelined AES engine between N_REQ requesters.
// Define AES_SCHED_PERF_EN to add saturating perf_jobs / perf_key_loads / perf_drain_cycles outputs.
module aes_job_scheduler #(
   parameter int N_REQ    = 2,
   parameter int PIPE_LAT = 11,
   parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [2*N_REQ-1:0]     req_type,
   input  logic [128*N_REQ-1:0]   req_data,
   input  logic [128*N_REQ-1:0]   req_key,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [1:0]             rsp_type,
   output logic [127:0]           rsp_data,
   output logic [1:0]             eng_in_type,
   output logic                   eng_set_key,
   output logic                   eng_halt,
   output logic [127:0]           eng_state,
   output logic [127:0]           eng_key,
   input  logic [127:0]           eng_out,
   input  logic [1:0]             eng_out_type
`ifdef AES_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_jobs,
   output logic [31:0]            perf_key_loads,
   output logic [31:0]            perf_drain_cycles
`endif
);

   localparam logic [1:0] JOB_INVALID = 2'd0;
   localparam int DEPTH   = PIPE_LAT + 1;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int STALE_W = $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

   state_t            state;
   logic              key_loaded;
   logic [127:0]      loaded_key;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   win_reg;
   logic [ID_W-1:0]   fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [STALE_W-1:0] stale_cnt;

   logic [1:0]        type_arr [N_REQ];
   logic [127:0]      data_arr [N_REQ];
   logic [127:0]      key_arr  [N_REQ];
   logic [N_REQ-1:0]  elig;

   logic              arb_found;
   logic [ID_W-1:0]   arb_win;
   logic [ID_W-1:0]   win;
   logic              key_match;
   logic              fifo_full;
   logic              eng_valid;
   logic              accept;
   logic              pop;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign type_arr[gi] = req_type[2*gi +: 2];
         assign data_arr[gi] = req_data[128*gi +: 128];
         assign key_arr[gi]  = req_key[128*gi +: 128];
         assign elig[gi]     = req_valid[gi] && (req_type[2*gi +: 2] != JOB_INVALID);
      end
   endgenerate

   always_comb begin
      int idx;
      idx       = 0;
      arb_found = 1'b0;
      arb_win   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % N_REQ;
         if (!arb_found && elig[idx]) begin
            arb_found = 1'b1;
            arb_win   = ID_W'(idx);
         end
      end
   end

   // Results still in the engine when reset hit are masked for PIPE_LAT cycles;
   // nothing halts the engine meanwhile, so all of them drain out in that window.
   assign eng_valid  = (eng_out_type != JOB_INVALID) && (stale_cnt == '0);
   assign pop        = eng_valid && rsp_ready;
   assign eng_halt   = eng_valid && !rsp_ready;
   assign win        = (state == RUN) ? arb_win : win_reg;
   assign key_match  = key_loaded && (key_arr[win] == loaded_key);
   assign fifo_full  = (count == CNT_W'(DEPTH));
   assign accept     = (state == RUN) && arb_found && key_match && !eng_halt && !fifo_full;
   assign count_next = count + CNT_W'(accept) - CNT_W'(pop);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win] = 1'b1;
   end

   assign eng_in_type = accept ? type_arr[win] : JOB_INVALID;
   assign eng_state   = accept ? data_arr[win] : '0;
   assign eng_set_key = (state == LOAD);
   assign eng_key     = (state == LOAD) ? key_arr[win_reg] : loaded_key;

   assign rsp_valid = eng_valid;
   assign rsp_id    = eng_valid ? fifo_mem[rd_ptr] : '0;
   assign rsp_type  = eng_valid ? eng_out_type : JOB_INVALID;
   assign rsp_data  = eng_valid ? eng_out : '0;

   always_ff @(posedge clk) begin
      if (accept) fifo_mem[wr_ptr] <= win;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         key_loaded <= 1'b0;
         loaded_key <= '0;
         rr_ptr     <= '0;
         win_reg    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         stale_cnt  <= STALE_W'(PIPE_LAT);
      end else begin
         if (stale_cnt != '0) stale_cnt <= stale_cnt - STALE_W'(1);
         if (accept) begin
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
            rr_ptr <= (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
         count <= count_next;
         case (state)
            RUN: begin
               if (arb_found && !key_match) begin
                  win_reg <= arb_win;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               if (count_next == '0) state <= LOAD;
            end
            LOAD: begin
               loaded_key <= key_arr[win_reg];
               key_loaded <= 1'b1;
               state      <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // Every engine result must have a requester tag waiting for it.
   tag_present: assert property (@(posedge clk) disable iff (rst) !(eng_valid && count == '0));

`ifdef AES_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_jobs         <= '0;
         perf_key_loads    <= '0;
         perf_drain_cycles <= '0;
      end else begin
         if (accept && perf_jobs != '1) perf_jobs <= perf_jobs + 32'd1;
         if (state == LOAD && perf_key_loads != '1) perf_key_loads <= perf_key_loads + 32'd1;
         if (state == DRAIN && perf_drain_cycles != '1) perf_drain_cycles <= perf_drain_cycles + 32'd1;
      end
   end
`endif

endmodule
